// File: rtl/cpri_tx_burst_gen_if.sv
// cpri_tx_burst_gen_if: bus between the antenna-data packer, the burst writer
// and the CPRI TX buffer RAM.
//   i_sop / i_dat         : frame-start strobe and input word (packer -> writer)
//   o_cpri_wen/waddr/wch  : buffer write enable, word address, channel index
//   o_cpri_wdata          : buffer write data
//   o_cpri_wlast/flast    : last word of channel / last word of frame
//   o_sop_err             : sop collided with an active burst
//   o_frm_cnt/o_err_cnt   : frame and collision statistics
// master = packer/buffer side, slave = burst writer.
interface cpri_tx_burst_gen_if #(
   parameter int unsigned DATA_W = 64,
   parameter int unsigned ADDR_W = 7,
   parameter int unsigned CH_W   = 1
);
   logic              i_sop;
   logic [DATA_W-1:0] i_dat;
   logic              o_cpri_wen;
   logic [ADDR_W-1:0] o_cpri_waddr;
   logic [CH_W-1:0]   o_cpri_wch;
   logic [DATA_W-1:0] o_cpri_wdata;
   logic              o_cpri_wlast;
   logic              o_cpri_flast;
   logic              o_sop_err;
   logic [15:0]       o_frm_cnt;
   logic [15:0]       o_err_cnt;

   modport master (
      output i_sop, i_dat,
      input  o_cpri_wen, o_cpri_waddr, o_cpri_wch, o_cpri_wdata,
             o_cpri_wlast, o_cpri_flast, o_sop_err, o_frm_cnt, o_err_cnt
   );

   modport slave (
      input  i_sop, i_dat,
      output o_cpri_wen, o_cpri_waddr, o_cpri_wch, o_cpri_wdata,
             o_cpri_wlast, o_cpri_flast, o_sop_err, o_frm_cnt, o_err_cnt
   );
endinterface

// File: rtl/cpri_tx_burst_gen.sv
// cpri_tx_burst_gen: captures NUM_CH x BURST_LEN words after a start-of-packet
// strobe and writes them into the CPRI TX buffer, two cycles after sampling.
// Ports:
//   clk  : sole clock
//   rst  : synchronous active-high reset
//   bus  : cpri_tx_burst_gen_if.slave (sop/data in, buffer write port out,
//          collision pulse, statistics)
// Optional feature: define CPRI_TX_STAT_EN to build the saturating frame and
// collision counters; otherwise o_frm_cnt / o_err_cnt are tied to zero.
module cpri_tx_burst_gen #(
   parameter int unsigned DATA_W         = 64,
   parameter int unsigned BURST_LEN      = 96,
   parameter int unsigned NUM_CH         = 1,
   parameter int unsigned ADDR_W         = $clog2(BURST_LEN),
   parameter int unsigned CH_W           = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
   parameter int unsigned RESTART_ON_SOP = 0
) (
   input logic                clk,
   input logic                rst,
   cpri_tx_burst_gen_if.slave bus
);

   localparam logic [ADDR_W-1:0] W_LAST = ADDR_W'(BURST_LEN - 1);
   localparam logic [CH_W-1:0]   C_LAST = CH_W'(NUM_CH - 1);
   localparam logic              RESTART = (RESTART_ON_SOP != 0);

   typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_e;

   state_e            state_q, state_d;
   logic [ADDR_W-1:0] wcnt_q, wcnt_d;
   logic [CH_W-1:0]   ccnt_q, ccnt_d;

   // capture stage
   logic              cap_vld_q,   cap_vld_d;
   logic [DATA_W-1:0] cap_dat_q,   cap_dat_d;
   logic [ADDR_W-1:0] cap_waddr_q, cap_waddr_d;
   logic [CH_W-1:0]   cap_wch_q,   cap_wch_d;
   logic              cap_wlast_q, cap_wlast_d;
   logic              cap_flast_q, cap_flast_d;
   logic              cap_err_q,   cap_err_d;

   // output stage
   logic              wen_q,   wen_d;
   logic [ADDR_W-1:0] waddr_q, waddr_d;
   logic [CH_W-1:0]   wch_q,   wch_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic              wlast_q, wlast_d;
   logic              flast_q, flast_d;
   logic              err_q,   err_d;

   // Next-state, counters and capture-stage inputs.
   // wcnt/ccnt in RUN always name the word being sampled this cycle.
   always_comb begin
      state_d     = state_q;
      wcnt_d      = wcnt_q;
      ccnt_d      = ccnt_q;
      cap_vld_d   = 1'b0;
      cap_dat_d   = cap_dat_q;
      cap_waddr_d = cap_waddr_q;
      cap_wch_d   = cap_wch_q;
      cap_wlast_d = 1'b0;
      cap_flast_d = 1'b0;
      cap_err_d   = 1'b0;

      unique case (state_q)
         IDLE: begin
            if (bus.i_sop) begin
               cap_vld_d   = 1'b1;
               cap_dat_d   = bus.i_dat;
               cap_waddr_d = '0;
               cap_wch_d   = '0;
               wcnt_d      = ADDR_W'(1);
               ccnt_d      = '0;
               state_d     = RUN;
            end
         end
         RUN: begin
            cap_vld_d = 1'b1;
            cap_dat_d = bus.i_dat;
            cap_err_d = bus.i_sop;
            if (bus.i_sop && RESTART) begin
               // this cycle's word becomes word 0 of channel 0
               cap_waddr_d = '0;
               cap_wch_d   = '0;
               wcnt_d      = ADDR_W'(1);
               ccnt_d      = '0;
            end else begin
               cap_waddr_d = wcnt_q;
               cap_wch_d   = ccnt_q;
               cap_wlast_d = (wcnt_q == W_LAST);
               cap_flast_d = (wcnt_q == W_LAST) && (ccnt_q == C_LAST);
               if (wcnt_q == W_LAST) begin
                  wcnt_d = '0;
                  if (ccnt_q == C_LAST) begin
                     ccnt_d  = '0;
                     state_d = IDLE;
                  end else begin
                     ccnt_d = ccnt_q + CH_W'(1);
                  end
               end else begin
                  wcnt_d = wcnt_q + ADDR_W'(1);
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Output stage: address/channel/data hold while no word is pending.
   always_comb begin
      wen_d   = cap_vld_q;
      waddr_d = waddr_q;
      wch_d   = wch_q;
      wdata_d = wdata_q;
      wlast_d = cap_vld_q & cap_wlast_q;
      flast_d = cap_vld_q & cap_flast_q;
      err_d   = cap_vld_q & cap_err_q;
      if (cap_vld_q) begin
         waddr_d = cap_waddr_q;
         wch_d   = cap_wch_q;
         wdata_d = cap_dat_q;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         wcnt_q      <= '0;
         ccnt_q      <= '0;
         cap_vld_q   <= 1'b0;
         cap_dat_q   <= '0;
         cap_waddr_q <= '0;
         cap_wch_q   <= '0;
         cap_wlast_q <= 1'b0;
         cap_flast_q <= 1'b0;
         cap_err_q   <= 1'b0;
         wen_q       <= 1'b0;
         waddr_q     <= '0;
         wch_q       <= '0;
         wdata_q     <= '0;
         wlast_q     <= 1'b0;
         flast_q     <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         wcnt_q      <= wcnt_d;
         ccnt_q      <= ccnt_d;
         cap_vld_q   <= cap_vld_d;
         cap_dat_q   <= cap_dat_d;
         cap_waddr_q <= cap_waddr_d;
         cap_wch_q   <= cap_wch_d;
         cap_wlast_q <= cap_wlast_d;
         cap_flast_q <= cap_flast_d;
         cap_err_q   <= cap_err_d;
         wen_q       <= wen_d;
         waddr_q     <= waddr_d;
         wch_q       <= wch_d;
         wdata_q     <= wdata_d;
         wlast_q     <= wlast_d;
         flast_q     <= flast_d;
         err_q       <= err_d;
      end
   end

   assign bus.o_cpri_wen   = wen_q;
   assign bus.o_cpri_waddr = waddr_q;
   assign bus.o_cpri_wch   = wch_q;
   assign bus.o_cpri_wdata = wdata_q;
   assign bus.o_cpri_wlast = wlast_q;
   assign bus.o_cpri_flast = flast_q;
   assign bus.o_sop_err    = err_q;

`ifdef CPRI_TX_STAT_EN
   logic [15:0] frm_cnt_q, frm_cnt_d;
   logic [15:0] err_cnt_q, err_cnt_d;

   // Saturating counters, stepped on the same edge as the flast / err write.
   always_comb begin
      frm_cnt_d = frm_cnt_q;
      err_cnt_d = err_cnt_q;
      if (flast_d && (frm_cnt_q != 16'hFFFF)) frm_cnt_d = frm_cnt_q + 16'd1;
      if (err_d && (err_cnt_q != 16'hFFFF))   err_cnt_d = err_cnt_q + 16'd1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         frm_cnt_q <= '0;
         err_cnt_q <= '0;
      end else begin
         frm_cnt_q <= frm_cnt_d;
         err_cnt_q <= err_cnt_d;
      end
   end

   assign bus.o_frm_cnt = frm_cnt_q;
   assign bus.o_err_cnt = err_cnt_q;
`else
   assign bus.o_frm_cnt = 16'd0;
   assign bus.o_err_cnt = 16'd0;
`endif

endmodule

// File: doc/cpri_tx_burst_gen.md
# cpri_tx_burst_gen

Parametrised CPRI transmit burst writer: on a start-of-packet strobe it captures a contiguous stream of `NUM_CH × BURST_LEN` data words and writes them into the CPRI TX buffer. Each write carries a registered enable, a per-channel word address, a channel index and last-word markers. It sits between the antenna-data packer and the CPRI TX buffer RAM. It generalises the fixed 96-word, single-channel generator with configurable width, depth and channel count, defined sop-collision handling, and optional statistics.

## Interface
- `DATA_W`, 64: data word width.
- `BURST_LEN`, 96: words per channel per frame; must be ≥2.
- `NUM_CH`, 1: channels per frame, sent back-to-back in ascending order; must be ≥1.
- `ADDR_W`, `$clog2(BURST_LEN)`: address width.
- `CH_W`, `NUM_CH>1 ? $clog2(NUM_CH) : 1`: channel index width.
- `RESTART_ON_SOP`, 0: 1 = sop during a burst restarts the frame; 0 = sop during a burst is ignored and flagged.
- `clk` in 1: sole clock.
- `rst` in 1: synchronous, active-high reset.
- `i_sop` in 1: frame start; the word on `i_dat` in the same cycle is word 0 of channel 0.
- `i_dat` in DATA_W: input word, sampled every cycle.
- `o_cpri_wen` out 1: buffer write enable.
- `o_cpri_waddr` out ADDR_W: word index within the channel, 0..BURST_LEN-1.
- `o_cpri_wch` out CH_W: channel index.
- `o_cpri_wdata` out DATA_W: write data.
- `o_cpri_wlast` out 1: last word of the current channel.
- `o_cpri_flast` out 1: last word of the frame (last channel, last word).
- `o_sop_err` out 1: one-cycle pulse when a sop collides with an active burst.
- `o_frm_cnt` out 16: completed frames (statistics).
- `o_err_cnt` out 16: sop collisions (statistics).

## Operation
- FSM states: IDLE and RUN. Counters: `wcnt` (0..BURST_LEN-1) and `ccnt` (0..NUM_CH-1).
- IDLE + `i_sop`: capture word 0 (`wcnt=0`, `ccnt=0`) and go to RUN.
- RUN: capture one word per cycle and increment `wcnt`.
  - When `wcnt` reaches BURST_LEN-1, it wraps to 0 and `ccnt` increments.
  - Once the word with `ccnt=NUM_CH-1` and `wcnt=BURST_LEN-1` has been captured, go to IDLE.
- Capture stage: register `i_dat`, `wcnt`, `ccnt`, a valid bit, and the wlast/flast flags. The output stage registers these again.
- `o_cpri_wlast` = 1 when `wcnt==BURST_LEN-1`. `o_cpri_flast` = wlast AND `ccnt==NUM_CH-1`.
- Frame end with sop in the same cycle: the last word is captured, and `i_sop` in the following cycle (FSM back in IDLE) starts a gapless next frame. A sop coinciding with the final captured word is a collision.
- Collision: `i_sop` while in RUN.
  - `RESTART_ON_SOP=1`: abandon the current frame; this cycle's word becomes word 0 of channel 0; `o_sop_err` pulses.
  - `RESTART_ON_SOP=0`: ignore the sop and continue the frame; `o_sop_err` pulses.
- While idle, `o_cpri_wen=0`. Address, channel and data outputs then hold their last values; only wen, wlast, flast and sop_err are forced to 0.

## Timing
- Latency: the word sampled in cycle N appears on the write outputs at cycle N+2. All outputs are registered.
- `o_sop_err` is asserted at cycle N+2 for a collision at cycle N, aligned with that word's write.
- Reset values: all outputs 0. The FSM goes to IDLE and both counters to 0.
- `rst` mid-burst: at the next edge all state is cleared and outputs are 0; no partial write continues. `i_sop` is ignored while `rst` is high.
- A frame produces exactly `NUM_CH*BURST_LEN` consecutive wen cycles with no bubbles.

## Configuration
- `CPRI_TX_STAT_EN` defined:
  - `o_frm_cnt` increments when a flast write is issued.
  - `o_err_cnt` increments on each `o_sop_err`.
  - Both counters saturate at 0xFFFF and are cleared by `rst`.
- Not defined: `o_frm_cnt` and `o_err_cnt` are tied to 0 and no counter logic is synthesised.

## Test plan
- Single frame (BURST_LEN=96, NUM_CH=1): sop at cycle 10 with `i_dat`=cycle index.
  - wen high in cycles 12..107.
  - waddr 0..95; wdata 10..105.
  - wlast and flast high only at cycle 107; `o_frm_cnt`=1.
- Multi-channel (NUM_CH=2):
  - 192 consecutive writes; wch is 0 for writes 1–96 and 1 for writes 97–192; waddr wraps 95→0.
  - wlast at writes 96 and 192; flast only at write 192.
- Back-to-back: second sop exactly 96 cycles after the first → 192 contiguous wen cycles, waddr wrapping 95→0, `o_sop_err` never asserted.
- Collision at sop+40:
  - `RESTART_ON_SOP=0`: the frame completes unchanged and `o_sop_err` pulses at cycle sop+42.
  - `RESTART_ON_SOP=1`: at cycle sop+42, waddr=0 and `o_sop_err`=1, and the frame then runs to 95.
  - Both cases (STAT_EN defined): `o_err_cnt`=1.
- Reset at word 50: from two cycles after the reset cycle, all outputs are 0 and no further wen occurs. A following sop starts a clean frame at address 0.
- Statistics saturation with `o_frm_cnt` forced near 0xFFFF:
  - STAT_EN defined: two frames → the count holds at 0xFFFF.
  - STAT_EN not defined: both counters read 0.
